// File: rtl/branch_checkpoint_buffer.sv
// In-flight branch tracker: one entry and one RAT checkpoint slot per dispatched branch.
// Optional BCB_TAG_RESOLVE_EN resolves by slot tag instead of the PC-CAM oldest match.
module branch_checkpoint_buffer #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [PC_W-1:0]  alloc_pc,
  output logic             alloc_ready,
  input  logic             resolve_valid,
  input  logic [PC_W-1:0]  resolve_pc,
`ifdef BCB_TAG_RESOLVE_EN
  input  logic [PTR_W-1:0] resolve_tag,
`endif
  input  logic             resolve_mispredict,
  output logic             copy_rat,
  output logic [PTR_W-1:0] copy_tag,
  output logic             paste_rat,
  output logic [PTR_W-1:0] paste_tag,
  output logic             retire_valid,
  output logic [PTR_W-1:0] retire_tag,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  logic [PC_W-1:0]  pc_q [DEPTH];
  logic [DEPTH-1:0] valid_q, resolved_q, squash;
  logic [PTR_W-1:0] head_q, tail_q, head_nxt, match_idx, rel_m, rel_j;
  logic             match_found, hit, mis, do_alloc, do_retire;
  logic [PTR_W:0]   count_nxt;

  assign alloc_ready = !full;

`ifdef BCB_TAG_RESOLVE_EN
  always_comb begin
    match_idx   = resolve_tag;
    match_found = valid_q[resolve_tag] && !resolved_q[resolve_tag];
  end
`else
  logic [PTR_W-1:0] scan_idx;

  // Scan from head so the first hit is the oldest outstanding branch with this PC.
  always_comb begin
    match_found = 1'b0;
    match_idx   = head_q;
    scan_idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (!match_found && valid_q[scan_idx] && !resolved_q[scan_idx] &&
          pc_q[scan_idx] == resolve_pc) begin
        match_found = 1'b1;
        match_idx   = scan_idx;
      end
    end
  end
`endif

  assign hit       = resolve_valid && match_found;
  assign mis       = hit && resolve_mispredict;
  assign do_retire = valid_q[head_q] && resolved_q[head_q];
  assign do_alloc  = alloc_valid && !full && !mis;
  assign head_nxt  = do_retire ? head_q + PTR_W'(1) : head_q;
  assign rel_m     = match_idx - head_q;

  // Squash range measured as distance from head, so a full buffer (tail == head) still works.
  always_comb begin
    squash = '0;
    rel_j  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      rel_j     = PTR_W'(j) - head_q;
      squash[j] = mis && (rel_j >= rel_m) && ({1'b0, rel_j} < count);
    end
  end

  always_comb begin
    if (mis) count_nxt = {1'b0, PTR_W'(match_idx - head_nxt)};
    else     count_nxt = count + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_retire);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) pc_q[k] <= '0;
      valid_q      <= '0;
      resolved_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      copy_rat     <= 1'b0;
      copy_tag     <= '0;
      paste_rat    <= 1'b0;
      paste_tag    <= '0;
      retire_valid <= 1'b0;
      retire_tag   <= '0;
    end else begin
      head_q <= head_nxt;
      if (mis)           tail_q <= match_idx;
      else if (do_alloc) tail_q <= tail_q + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));

      for (int k = 0; k < DEPTH; k++) begin
        if (squash[k]) begin
          valid_q[k]    <= 1'b0;
          resolved_q[k] <= 1'b0;
        end
      end
      if (do_alloc) begin
        pc_q[tail_q]       <= alloc_pc;
        valid_q[tail_q]    <= 1'b1;
        resolved_q[tail_q] <= 1'b0;
      end
      if (do_retire) begin
        valid_q[head_q]    <= 1'b0;
        resolved_q[head_q] <= 1'b0;
      end
      if (hit && !mis) resolved_q[match_idx] <= 1'b1;

      copy_rat     <= do_alloc;
      paste_rat    <= mis;
      retire_valid <= do_retire;
      if (do_alloc)  copy_tag   <= tail_q;
      if (mis)       paste_tag  <= match_idx;
      if (do_retire) retire_tag <= head_q;
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_buffer.sv
// Directed bench for branch_checkpoint_buffer (DEPTH=8, PC_W=32, PC-CAM lookup).
module tb_branch_checkpoint_buffer;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             alloc_valid = 1'b0;
  logic [PC_W-1:0]  alloc_pc = '0;
  logic             alloc_ready;
  logic             resolve_valid = 1'b0;
  logic [PC_W-1:0]  resolve_pc = '0;
  logic             resolve_mispredict = 1'b0;
  logic             copy_rat, paste_rat, retire_valid, empty, full;
  logic [PTR_W-1:0] copy_tag, paste_tag, retire_tag;
  logic [PTR_W:0]   count;

  int total = 0;
  int bad   = 0;

  branch_checkpoint_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_ready(alloc_ready),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_mispredict(resolve_mispredict),
    .copy_rat(copy_rat), .copy_tag(copy_tag),
    .paste_rat(paste_rat), .paste_tag(paste_tag),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid        = 1'b0;
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic alloc(input logic [31:0] pc, input int tag, input string name);
    alloc_valid = 1'b1;
    alloc_pc    = pc;
    cyc();
    alloc_valid = 1'b0;
    chk({name, "_copy_rat"}, 32'(copy_rat), 1);
    chk({name, "_copy_tag"}, 32'(copy_tag), 32'(tag));
  endtask

  task automatic resolve(input logic [31:0] pc, input logic mp);
    resolve_valid      = 1'b1;
    resolve_pc         = pc;
    resolve_mispredict = mp;
    cyc();
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_copy", 32'(copy_rat), 0);
    chk("rst_paste", 32'(paste_rat), 0);
    chk("rst_retire", 32'(retire_valid), 0);

    // three allocs
    alloc(32'h100, 0, "a0");
    alloc(32'h200, 1, "a1");
    alloc(32'h300, 2, "a2");
    chk("a3_count", 32'(count), 3);
    chk("a3_empty", 32'(empty), 0);
    cyc();
    chk("copy_pulse_width", 32'(copy_rat), 0);

    // fill to DEPTH
    alloc(32'h400, 3, "f3");
    alloc(32'h500, 4, "f4");
    alloc(32'h600, 5, "f5");
    alloc(32'h700, 6, "f6");
    alloc(32'h800, 7, "f7");
    chk("full_count", 32'(count), 8);
    chk("full_flag", 32'(full), 1);
    chk("full_ready", 32'(alloc_ready), 0);
    alloc_valid = 1'b1;
    alloc_pc    = 32'h900;
    cyc();
    chk("ninth_copy", 32'(copy_rat), 0);
    chk("ninth_count", 32'(count), 8);
    // correct resolve of head while alloc keeps being presented
    resolve_valid = 1'b1;
    resolve_pc    = 32'h100;
    cyc();
    resolve_valid = 1'b0;
    chk("res_retire_early", 32'(retire_valid), 0);
    chk("res_copy", 32'(copy_rat), 0);
    cyc();
    chk("ret0_valid", 32'(retire_valid), 1);
    chk("ret0_tag", 32'(retire_tag), 0);
    chk("ret0_alloc_blocked", 32'(copy_rat), 0);
    chk("ret0_count", 32'(count), 7);
    chk("ret0_ready", 32'(alloc_ready), 1);
    cyc();
    alloc_valid = 1'b0;
    chk("wrap_copy", 32'(copy_rat), 1);
    chk("wrap_tag", 32'(copy_tag), 0);
    chk("wrap_count", 32'(count), 8);
    chk("wrap_retire_width", 32'(retire_valid), 0);

    // mispredict overrides same-cycle alloc
    do_reset();
    alloc(32'h100, 0, "m0");
    alloc(32'h200, 1, "m1");
    alloc(32'h300, 2, "m2");
    alloc(32'h400, 3, "m3");
    alloc(32'h500, 4, "m4");
    alloc_valid        = 1'b1;
    alloc_pc           = 32'h900;
    resolve_valid      = 1'b1;
    resolve_pc         = 32'h300;
    resolve_mispredict = 1'b1;
    cyc();
    idle();
    chk("mp_paste", 32'(paste_rat), 1);
    chk("mp_paste_tag", 32'(paste_tag), 2);
    chk("mp_count", 32'(count), 2);
    chk("mp_no_copy", 32'(copy_rat), 0);
    alloc(32'h900, 2, "mp_realloc");
    chk("mp_paste_width", 32'(paste_rat), 0);
    chk("mp_realloc_count", 32'(count), 3);
    resolve(32'h400, 1'b1);
    chk("squashed_nomatch", 32'(paste_rat), 0);
    chk("squashed_count", 32'(count), 3);

    // duplicate PC: oldest wins
    do_reset();
    alloc(32'h100, 0, "d0");
    alloc(32'h400, 1, "d1");
    alloc(32'h200, 2, "d2");
    alloc(32'h400, 3, "d3");
    resolve(32'h400, 1'b1);
    chk("dup_paste", 32'(paste_rat), 1);
    chk("dup_tag", 32'(paste_tag), 1);
    chk("dup_count", 32'(count), 1);

    // move head to 6, then wrap
    do_reset();
    for (int i = 0; i < 6; i++) alloc(32'(16 * (i + 1)), i, "w_pre");
    for (int i = 0; i < 6; i++) resolve(32'(16 * (i + 1)), 1'b0);
    cyc();
    cyc();
    chk("w_empty", 32'(empty), 1);
    chk("w_count0", 32'(count), 0);
    alloc(32'hA0, 6, "w6");
    alloc(32'hB0, 7, "w7");
    alloc(32'hC0, 0, "w0");
    alloc(32'hD0, 1, "w1");
    chk("w_count4", 32'(count), 4);
    resolve(32'hB0, 1'b1);
    chk("w_paste", 32'(paste_rat), 1);
    chk("w_paste_tag", 32'(paste_tag), 7);
    chk("w_count1", 32'(count), 1);
    alloc(32'hE0, 7, "w_realloc");
    chk("w_count2", 32'(count), 2);

    // out-of-order correct resolves retire in order
    do_reset();
    alloc(32'h100, 0, "o0");
    alloc(32'h200, 1, "o1");
    resolve(32'h200, 1'b0);
    chk("o_no_retire1", 32'(retire_valid), 0);
    resolve(32'h100, 1'b0);
    chk("o_no_retire2", 32'(retire_valid), 0);
    cyc();
    chk("o_ret_a", 32'(retire_valid), 1);
    chk("o_ret_a_tag", 32'(retire_tag), 0);
    cyc();
    chk("o_ret_b", 32'(retire_valid), 1);
    chk("o_ret_b_tag", 32'(retire_tag), 1);
    chk("o_empty", 32'(empty), 1);

    // async reset mid-sequence
    alloc(32'h10, 2, "r0");
    alloc(32'h20, 3, "r1");
    resolve(32'h10, 1'b0);
    alloc(32'h30, 4, "r2");
    rst = 1'b0;
    #2;
    chk("ar_copy", 32'(copy_rat), 0);
    chk("ar_copy_tag", 32'(copy_tag), 0);
    chk("ar_retire", 32'(retire_valid), 0);
    chk("ar_retire_tag", 32'(retire_tag), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_ready", 32'(alloc_ready), 1);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk("ar_after_retire", 32'(retire_valid), 0);
    chk("ar_after_count", 32'(count), 0);
    alloc(32'h40, 0, "ar_first");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
